// File: rtl/execution_condition_tracker.sv
`default_nettype none
// execution_condition_tracker: NUM_ECRS-entry ECR file (free -> busy -> resolved -> free) with SIC resolve ports.
// Optional macro ECR_OWNER_CHECK_EN: a resolve is only accepted when sic_write_id matches the entry owner.
module execution_condition_tracker #(
   parameter int NUM_ECRS = 4,
   parameter int NUM_SICS = 2,
   parameter int ID_WIDTH = 16,
   parameter int AW       = $clog2(NUM_ECRS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc_req,
   input  logic [ID_WIDTH-1:0] alloc_owner_id,
   output logic                alloc_grant,
   output logic [AW-1:0]       alloc_idx,
   input  logic                free_en,
   input  logic [AW-1:0]       free_idx,
   input  logic                flush_en,
   input  logic [ID_WIDTH-1:0] flush_id,
   input  logic [AW-1:0]       sic_read_addr  [NUM_SICS],
   output logic [1:0]          sic_read_data  [NUM_SICS],
   input  logic                sic_wen        [NUM_SICS],
   input  logic [AW-1:0]       sic_write_addr [NUM_SICS],
   input  logic [1:0]          sic_wdata      [NUM_SICS],
   input  logic [ID_WIDTH-1:0] sic_write_id   [NUM_SICS],
   output logic                sic_write_err  [NUM_SICS],
   output logic [1:0]          monitor_states [NUM_ECRS],
   output logic [AW:0]         free_count
);

   typedef enum logic [1:0] {
      ST_BUSY      = 2'b00,
      ST_NOT_TAKEN = 2'b01,
      ST_TAKEN     = 2'b10,
      ST_FREE      = 2'b11
   } ecr_state_e;

   ecr_state_e          state_q  [NUM_ECRS];
   ecr_state_e          state_d  [NUM_ECRS];
   logic [ID_WIDTH-1:0] owner_q  [NUM_ECRS];
   logic [ID_WIDTH-1:0] owner_d  [NUM_ECRS];
   logic                err_q    [NUM_SICS];
   logic                err_d    [NUM_SICS];
   logic [ID_WIDTH-1:0] age_w    [NUM_ECRS];
   logic                kill_w   [NUM_ECRS];
   logic                legal_w  [NUM_SICS];
   logic                accept_w [NUM_SICS];
   logic                any_free_w;

   // Descending scan leaves the lowest FREE index in alloc_idx.
   always_comb begin
      any_free_w = 1'b0;
      alloc_idx  = '0;
      free_count = '0;
      for (int e = NUM_ECRS - 1; e >= 0; e--) begin
         if (state_q[e] == ST_FREE) begin
            any_free_w = 1'b1;
            alloc_idx  = AW'(e);
            free_count = free_count + (AW + 1)'(1);
         end
      end
      alloc_grant = alloc_req && !flush_en && any_free_w;
   end

   // Owner is younger when the wrapped difference is positive in signed ID_WIDTH arithmetic.
   always_comb begin
      for (int e = 0; e < NUM_ECRS; e++) begin
         age_w[e]  = owner_q[e] - flush_id;
         kill_w[e] = (flush_en && (state_q[e] != ST_FREE) &&
                      !age_w[e][ID_WIDTH-1] && (age_w[e] != '0)) ||
                     (free_en && (free_idx == AW'(e)));
      end
   end

   always_comb begin
      for (int s = 0; s < NUM_SICS; s++) begin
         legal_w[s] = sic_wen[s] &&
                      (state_q[sic_write_addr[s]] == ST_BUSY) &&
                      ((sic_wdata[s] == 2'b01) || (sic_wdata[s] == 2'b10))
`ifdef ECR_OWNER_CHECK_EN
                      && (owner_q[sic_write_addr[s]] == sic_write_id[s])
`endif
                      ;
      end
   end

`ifndef ECR_OWNER_CHECK_EN
   logic [NUM_SICS-1:0] unused_write_id_w;
   always_comb begin
      for (int s = 0; s < NUM_SICS; s++) begin
         unused_write_id_w[s] = ^sic_write_id[s];
      end
   end
`endif

   // A lower-index legal resolve to the same entry wins; a free/flush on the entry silences the error.
   always_comb begin
      for (int s = 0; s < NUM_SICS; s++) begin
         logic lost;
         lost = 1'b0;
         for (int j = 0; j < s; j++) begin
            if (legal_w[j] && (sic_write_addr[j] == sic_write_addr[s])) begin
               lost = 1'b1;
            end
         end
         accept_w[s] = legal_w[s] && !lost && !kill_w[sic_write_addr[s]];
         err_d[s]    = sic_wen[s] && !kill_w[sic_write_addr[s]] && !(legal_w[s] && !lost);
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (alloc_grant) begin
         state_d[alloc_idx] = ST_BUSY;
         owner_d[alloc_idx] = alloc_owner_id;
      end
      for (int s = 0; s < NUM_SICS; s++) begin
         if (accept_w[s]) begin
            state_d[sic_write_addr[s]] = ecr_state_e'(sic_wdata[s]);
         end
      end
      for (int e = 0; e < NUM_ECRS; e++) begin
         if (kill_w[e]) begin
            state_d[e] = ST_FREE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < NUM_ECRS; e++) begin
            state_q[e] <= ST_FREE;
            owner_q[e] <= '0;
         end
         for (int s = 0; s < NUM_SICS; s++) begin
            err_q[s] <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      for (int e = 0; e < NUM_ECRS; e++) begin
         monitor_states[e] = state_q[e];
      end
      for (int s = 0; s < NUM_SICS; s++) begin
         sic_read_data[s] = state_q[sic_read_addr[s]];
         sic_write_err[s] = err_q[s];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_execution_condition_tracker.sv
`default_nettype none
// tb_execution_condition_tracker: scoreboard bench for the ECR file (default parameters).
module tb_execution_condition_tracker;

`ifdef ECR_OWNER_CHECK_EN
   localparam bit OWN = 1'b1;
`else
   localparam bit OWN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_req;
   logic [15:0] alloc_owner_id;
   logic        alloc_grant;
   logic [1:0]  alloc_idx;
   logic        free_en;
   logic [1:0]  free_idx;
   logic        flush_en;
   logic [15:0] flush_id;
   logic [1:0]  sic_read_addr  [2];
   logic [1:0]  sic_read_data  [2];
   logic        sic_wen        [2];
   logic [1:0]  sic_write_addr [2];
   logic [1:0]  sic_wdata      [2];
   logic [15:0] sic_write_id   [2];
   logic        sic_write_err  [2];
   logic [1:0]  monitor_states [4];
   logic [2:0]  free_count;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } item_t;

   item_t exp_q[$];
   item_t obs_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   execution_condition_tracker #(.NUM_ECRS(4), .NUM_SICS(2), .ID_WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .alloc_req     (alloc_req),
      .alloc_owner_id(alloc_owner_id),
      .alloc_grant   (alloc_grant),
      .alloc_idx     (alloc_idx),
      .free_en       (free_en),
      .free_idx      (free_idx),
      .flush_en      (flush_en),
      .flush_id      (flush_id),
      .sic_read_addr (sic_read_addr),
      .sic_read_data (sic_read_data),
      .sic_wen       (sic_wen),
      .sic_write_addr(sic_write_addr),
      .sic_wdata     (sic_wdata),
      .sic_write_id  (sic_write_id),
      .sic_write_err (sic_write_err),
      .monitor_states(monitor_states),
      .free_count    (free_count)
   );

   always #5 clk = ~clk;

   function automatic void expect_v(string tag, logic [31:0] v);
      exp_q.push_back('{tag, v});
   endfunction

   function automatic void observe(string tag, logic [31:0] v);
      obs_q.push_back('{tag, v});
   endfunction

   task automatic idle();
      alloc_req = 1'b0; alloc_owner_id = '0;
      free_en   = 1'b0; free_idx       = '0;
      flush_en  = 1'b0; flush_id       = '0;
      for (int s = 0; s < 2; s++) begin
         sic_read_addr[s] = '0; sic_wen[s] = 1'b0; sic_write_addr[s] = '0;
         sic_wdata[s] = '0; sic_write_id[s] = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int e = 0; e < 4; e++) begin
         expect_v($sformatf("reset_state%0d", e), 32'd3);
         observe($sformatf("reset_state%0d", e), 32'(monitor_states[e]));
      end
      expect_v("reset_free_count", 32'd4);     observe("reset_free_count", 32'(free_count));
      expect_v("reset_alloc_grant", 32'd0);    observe("reset_alloc_grant", 32'(alloc_grant));
      expect_v("reset_err0", 32'd0);           observe("reset_err0", 32'(sic_write_err[0]));
      expect_v("reset_err1", 32'd0);           observe("reset_err1", 32'(sic_write_err[1]));
      while (exp_q.size() != 0) begin
         item_t e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.v !== e.v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", e.tag, o.v, e.v);
         end
      end
   endtask

   task automatic test_alloc();
      for (int i = 0; i < 5; i++) begin
         tick(); idle();
         alloc_req = 1'b1; alloc_owner_id = 16'(5 + i);
         expect_v($sformatf("alloc_grant%0d", i), (i < 4) ? 32'd1 : 32'd0);
         expect_v($sformatf("alloc_idx%0d", i), (i < 4) ? 32'(i) : 32'd0);
         expect_v($sformatf("alloc_free_count%0d", i), (i < 4) ? 32'(4 - i) : 32'd0);
         #2;
         observe("", 32'(alloc_grant)); observe("", 32'(alloc_idx)); observe("", 32'(free_count));
      end
      tick(); idle(); #2;
      for (int e = 0; e < 4; e++) begin
         expect_v($sformatf("alloc_busy%0d", e), 32'd0);
         observe("", 32'(monitor_states[e]));
      end
      while (exp_q.size() != 0) begin
         item_t e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.v !== e.v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", e.tag, o.v, e.v);
         end
      end
   endtask

   task automatic test_resolve();
      tick(); idle();
      sic_wen[0] = 1'b1; sic_write_addr[0] = 2'd1; sic_wdata[0] = 2'b10; sic_write_id[0] = 16'd6;
      sic_read_addr[0] = 2'd1;
      expect_v("resolve_no_bypass", 32'd0);
      #2; observe("", 32'(sic_read_data[0]));

      tick(); idle(); sic_read_addr[0] = 2'd1;
      sic_wen[1] = 1'b1; sic_write_addr[1] = 2'd1; sic_wdata[1] = 2'b01; sic_write_id[1] = 16'd9;
      expect_v("resolve_state1", 32'd2); expect_v("resolve_read0", 32'd2); expect_v("resolve_err0", 32'd0);
      #2;
      observe("", 32'(monitor_states[1])); observe("", 32'(sic_read_data[0])); observe("", 32'(sic_write_err[0]));

      tick(); idle();
      sic_wen[0] = 1'b1; sic_write_addr[0] = 2'd2; sic_wdata[0] = 2'b01; sic_write_id[0] = 16'd9;
      expect_v("reject_err1", 32'd1); expect_v("reject_state1", 32'd2);
      #2; observe("", 32'(sic_write_err[1])); observe("", 32'(monitor_states[1]));

      tick(); idle();
      sic_wen[0] = 1'b1; sic_write_addr[0] = 2'd3; sic_wdata[0] = 2'b11; sic_write_id[0] = 16'd8;
      expect_v("reject_err1_pulse", 32'd0);
      expect_v("owner_id_err0", OWN ? 32'd1 : 32'd0);
      expect_v("owner_id_state2", OWN ? 32'd0 : 32'd1);
      #2;
      observe("", 32'(sic_write_err[1])); observe("", 32'(sic_write_err[0])); observe("", 32'(monitor_states[2]));

      tick(); idle();
      expect_v("bad_wdata_err0", 32'd1); expect_v("bad_wdata_state3", 32'd0);
      #2; observe("", 32'(sic_write_err[0])); observe("", 32'(monitor_states[3]));

      tick(); idle();
      expect_v("bad_wdata_err0_pulse", 32'd0);
      #2; observe("", 32'(sic_write_err[0]));
      while (exp_q.size() != 0) begin
         item_t e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.v !== e.v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", e.tag, o.v, e.v);
         end
      end
   endtask

   task automatic test_flush_wrap();
      logic [15:0] ids [4];
      ids[0] = 16'hFFFE; ids[1] = 16'hFFFF; ids[2] = 16'h0000; ids[3] = 16'h0001;
      for (int i = 0; i < 4; i++) begin
         tick(); idle(); free_en = 1'b1; free_idx = 2'(i);
      end
      tick(); idle();
      expect_v("free_all_count", 32'd4);
      #2; observe("", 32'(free_count));
      for (int i = 0; i < 4; i++) begin
         tick(); idle(); alloc_req = 1'b1; alloc_owner_id = ids[i];
         expect_v($sformatf("wrap_alloc_idx%0d", i), 32'(i));
         #2; observe("", 32'(alloc_idx));
      end
      tick(); idle();
      flush_en = 1'b1; flush_id = 16'hFFFF; alloc_req = 1'b1; alloc_owner_id = 16'h1234;
      expect_v("flush_blocks_grant", 32'd0);
      #2; observe("", 32'(alloc_grant));
      tick(); idle();
      expect_v("wrap_state0", 32'd0); expect_v("wrap_state1", 32'd0);
      expect_v("wrap_state2", 32'd3); expect_v("wrap_state3", 32'd3);
      expect_v("wrap_free_count", 32'd2);
      #2;
      for (int e = 0; e < 4; e++) observe("", 32'(monitor_states[e]));
      observe("", 32'(free_count));
      while (exp_q.size() != 0) begin
         item_t e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.v !== e.v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", e.tag, o.v, e.v);
         end
      end
   endtask

   task automatic test_priority();
      tick(); idle(); alloc_req = 1'b1; alloc_owner_id = 16'h0010;
      expect_v("prio_alloc_idx2", 32'd2);
      #2; observe("", 32'(alloc_idx));
      tick(); idle(); alloc_req = 1'b1; alloc_owner_id = 16'h0003;
      expect_v("prio_alloc_idx3", 32'd3);
      #2; observe("", 32'(alloc_idx));
      tick(); idle();
      flush_en = 1'b1; flush_id = 16'h0005;
      free_en = 1'b1; free_idx = 2'd0;
      sic_wen[0] = 1'b1; sic_write_addr[0] = 2'd3; sic_wdata[0] = 2'b01; sic_write_id[0] = 16'h0003;
      sic_wen[1] = 1'b1; sic_write_addr[1] = 2'd2; sic_wdata[1] = 2'b10; sic_write_id[1] = 16'h0010;
      alloc_req = 1'b1; alloc_owner_id = 16'h0055;
      expect_v("prio_grant_blocked", 32'd0);
      #2; observe("", 32'(alloc_grant));
      tick(); idle();
      expect_v("prio_state0", 32'd3); expect_v("prio_state1", 32'd0);
      expect_v("prio_state2", 32'd3); expect_v("prio_state3", 32'd1);
      expect_v("prio_err0", 32'd0);   expect_v("prio_err1", 32'd0);
      expect_v("prio_free_count", 32'd2);
      #2;
      for (int e = 0; e < 4; e++) observe("", 32'(monitor_states[e]));
      observe("", 32'(sic_write_err[0])); observe("", 32'(sic_write_err[1])); observe("", 32'(free_count));
      while (exp_q.size() != 0) begin
         item_t e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.v !== e.v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", e.tag, o.v, e.v);
         end
      end
   endtask

   task automatic test_dual_sic();
      tick(); idle(); alloc_req = 1'b1; alloc_owner_id = 16'h0020;
      expect_v("dual_alloc_grant", 32'd1); expect_v("dual_alloc_idx", 32'd0);
      #2; observe("", 32'(alloc_grant)); observe("", 32'(alloc_idx));
      tick(); idle();
      for (int s = 0; s < 2; s++) begin
         sic_wen[s] = 1'b1; sic_write_addr[s] = 2'd0; sic_write_id[s] = 16'h0020;
      end
      sic_wdata[0] = 2'b10; sic_wdata[1] = 2'b01;
      tick(); idle();
      expect_v("dual_state0", 32'd2); expect_v("dual_err0", 32'd0); expect_v("dual_err1", 32'd1);
      #2;
      observe("", 32'(monitor_states[0])); observe("", 32'(sic_write_err[0])); observe("", 32'(sic_write_err[1]));
      while (exp_q.size() != 0) begin
         item_t e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.v !== e.v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", e.tag, o.v, e.v);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [1:0] want [3];
      want[0] = 2'd0; want[1] = 2'd2; want[2] = 2'd3;
      tick(); idle(); free_en = 1'b1; free_idx = 2'd0;
      tick(); idle(); free_en = 1'b1; free_idx = 2'd3;
      for (int i = 0; i < 3; i++) begin
         tick(); idle(); alloc_req = 1'b1; alloc_owner_id = 16'(16'h0100 + i);
         expect_v($sformatf("fill_idx%0d", i), 32'(want[i]));
         #2; observe("", 32'(alloc_idx));
      end
      tick(); idle();
      for (int e = 0; e < 4; e++) expect_v($sformatf("full_state%0d", e), 32'd0);
      expect_v("full_free_count", 32'd0);
      #2;
      for (int e = 0; e < 4; e++) observe("", 32'(monitor_states[e]));
      observe("", 32'(free_count));
      #1 rst = 1'b1;
      for (int e = 0; e < 4; e++) expect_v($sformatf("async_state%0d", e), 32'd3);
      expect_v("async_free_count", 32'd4);
      expect_v("async_grant", 32'd0);
      #1;
      for (int e = 0; e < 4; e++) observe("", 32'(monitor_states[e]));
      observe("", 32'(free_count)); observe("", 32'(alloc_grant));
      #2 rst = 1'b0;
      while (exp_q.size() != 0) begin
         item_t e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o.v !== e.v) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", e.tag, o.v, e.v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_resolve();
      test_flush_wrap();
      test_priority();
      test_dual_sic();
      test_async_reset();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/execution_condition_tracker.md
# execution_condition_tracker

Parametrised execution-condition register (ECR) file for the superscalar machine: generalises the fixed two-entry ECR store to NUM_ECRS entries with lifecycle tracking (free → busy → resolved → free). The issue controller allocates and releases entries. SICs resolve branch outcomes into entries. A rollback frees every entry owned by instructions younger than the flush point. The block sits between the issue controller (alloc/free/flush, monitor) and the SIC array (read/resolve ports).

## Interface
- NUM_ECRS, 4, number of ECR entries (≥2); AW = $clog2(NUM_ECRS)
- NUM_SICS, 2, number of SIC read/resolve port pairs
- ID_WIDTH, 16, issue-id width (wrapping sequence number)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alloc_req  in  1  issue controller requests an entry
- alloc_owner_id  in  ID_WIDTH  issue id of the branch that will own the entry
- alloc_grant  out  1  combinational; request accepted this cycle
- alloc_idx  out  AW  combinational; index granted (lowest FREE index)
- free_en  in  1  release entry
- free_idx  in  AW  entry to release
- flush_en  in  1  rollback pulse
- flush_id  in  ID_WIDTH  issue id of the mispredicted branch; strictly younger owners are discarded
- sic_read_addr[NUM_SICS]  in  AW  per-SIC read address
- sic_read_data[NUM_SICS]  out  2  combinational state of addressed entry
- sic_wen[NUM_SICS]  in  1  resolve request
- sic_write_addr[NUM_SICS]  in  AW  entry to resolve
- sic_wdata[NUM_SICS]  in  2  01 = not taken, 10 = taken
- sic_write_id[NUM_SICS]  in  ID_WIDTH  issue id of the resolving SIC
- sic_write_err[NUM_SICS]  out  1  registered; one-cycle pulse on a rejected resolve
- monitor_states[NUM_ECRS]  out  2  state of every entry
- free_count  out  AW+1  number of FREE entries

## Operation
- State encoding: 00 BUSY, 01 NOT_TAKEN, 10 TAKEN, 11 FREE. Each entry also stores owner_id.
- Reset: all entries FREE, owner_id 0, sic_write_err 0, free_count = NUM_ECRS, alloc_grant 0.
- Alloc: alloc_grant = alloc_req && !flush_en && (any FREE). On grant, the entry at alloc_idx becomes BUSY with owner_id = alloc_owner_id. alloc_idx = lowest FREE index, or 0 when none is FREE.
- Resolve: accepted only if the entry is BUSY, sic_wdata ∈ {01, 10}, and owner_id == sic_write_id. On acceptance, the state becomes sic_wdata. Otherwise the write is dropped and sic_write_err pulses.
- Free: free_en sets the entry FREE from any state. Freeing a BUSY entry cancels it. Freeing a FREE entry is a no-op.
- Flush: every non-FREE entry whose owner is younger than flush_id becomes FREE. "Younger" means the signed ID_WIDTH difference (owner_id − flush_id) > 0, so the comparison is correct across wrap-around. The flush_id owner and all older owners are kept.
- Per-entry priority within one edge: flush > free > resolve > alloc. Alloc can only target an entry already FREE, so alloc never conflicts with resolve.
- Two SICs resolving the same entry in one cycle: the lower SIC index wins. The higher-index SIC gets sic_write_err.
- A resolve that loses to free or flush on the same entry: the write is dropped with no error.

## Timing
- Reads are combinational from registered state, with no write bypass. A resolve at edge N is visible on sic_read_data and monitor_states after edge N.
- Alloc is a single-cycle handshake. The grant is combinational, and the entry reads BUSY from the next cycle.
- free_count is a combinational popcount of registered state, so it updates the cycle after alloc, free or flush.
- sic_write_err is asserted for exactly the cycle after the rejected resolve.
- rst asserted mid-operation immediately forces all reset values, independent of clk.

## Configuration
- ECR_OWNER_CHECK_EN defined: resolve requires owner_id == sic_write_id, as described above.
- ECR_OWNER_CHECK_EN undefined: owner_id is still stored and used for flush, but resolve ignores sic_write_id. Only the BUSY check and the wdata legality check apply.

## Test plan
- Reset, then alloc_req with ids 5, 6, 7, 8 on consecutive cycles → alloc_idx 0, 1, 2, 3 granted; fifth request → alloc_grant 0; free_count 4→0.
- Entry 1 BUSY owner 6; SIC0 resolves wdata 10 with id 6 → monitor_states[1] = 10 the next cycle. SIC1 writes entry 1 with id 9 → sic_write_err[1] pulses, state unchanged.
- Owners 0xFFFE, 0xFFFF, 0x0000, 0x0001 (ID_WIDTH 16); flush_id 0xFFFF → only the 0x0000 and 0x0001 entries become FREE; free_count = 2.
- Same cycle: flush frees entry 2, free_en on entry 0, SIC0 resolves entry 3 → entries 0 and 2 FREE, entry 3 resolved, no errors; alloc_req in that cycle → alloc_grant 0.
- SIC0 and SIC1 both resolve BUSY entry 0 (10 vs 01) → state 10; only sic_write_err[1] pulses.
- rst pulsed asynchronously between edges with all entries BUSY → all monitor_states = 11 and free_count = NUM_ECRS immediately.
